// File: rtl/johnson_decoder_if.sv
// Sample/decode bundle between a Johnson-code sampler (master) and the decoder (slave).
// Index width follows the sequence length of 2*WIDTH states.
interface johnson_decoder_if #(
    parameter int WIDTH = 4
);
    localparam int IW = $clog2(2 * WIDTH);

    logic             valid_in;
    logic [WIDTH-1:0] code_in;
    logic [IW-1:0]    index;
    logic             index_valid;
    logic             illegal;
    logic             seq_err;
    logic             locked;
    logic [7:0]       wrap_cnt;
    logic [7:0]       err_cnt;

    modport master (
        output valid_in, code_in,
        input  index, index_valid, illegal, seq_err, locked, wrap_cnt, err_cnt
    );

    modport slave (
        input  valid_in, code_in,
        output index, index_valid, illegal, seq_err, locked, wrap_cnt, err_cnt
    );
endinterface

// File: rtl/johnson_decoder.sv
// Johnson-code receiver: decodes sampled codes to a step index, tracks sequence lock,
// and reports illegal codes, out-of-sequence steps, full-cycle wraps and an error count.
module johnson_decoder #(
    parameter int WIDTH      = 4,
    parameter int LOCK_CNT   = 3,
    parameter bit ALLOW_HOLD = 1'b0
) (
    input  logic               clk,
    input  logic               reset_n,
    johnson_decoder_if.slave   bus
);
    localparam int SEQ_LEN = 2 * WIDTH;
    localparam int IW      = $clog2(SEQ_LEN);
    localparam logic [WIDTH-1:0] ONES = '1;

    typedef enum logic [1:0] {HUNT, CHECK, LOCKED} state_t;

    state_t        state;
    logic [3:0]    good_cnt;
    logic [IW-1:0] index_q;
    logic          index_valid_q;
    logic          illegal_q;
    logic          seq_err_q;
    logic          locked_q;
    logic [7:0]    wrap_cnt_q;
    logic [7:0]    err_cnt_q;

    logic          code_legal;
    logic [IW-1:0] code_idx;
    logic [IW-1:0] next_idx;
    logic          is_succ;
    logic          is_hold;

    // Legal codes are a run of ones anchored at the MSB (index k) or, with the
    // MSB clear, anchored at the LSB (index SEQ_LEN-k).
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        code_legal = 1'b0;
        code_idx   = '0;
        for (int k = 0; k <= WIDTH; k++) begin
            if (bus.code_in == ~(ONES >> k)) begin
                code_legal = 1'b1;
                code_idx   = IW'(k);
            end
        end
        for (int k = 1; k < WIDTH; k++) begin
            if (bus.code_in == (ONES >> (WIDTH - k))) begin
                code_legal = 1'b1;
                code_idx   = IW'(SEQ_LEN - k);
            end
        end
    end

    assign next_idx = (index_q == IW'(SEQ_LEN - 1)) ? '0 : index_q + IW'(1);
    assign is_succ  = code_legal && (code_idx == next_idx);
    assign is_hold  = code_legal && (code_idx == index_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= HUNT;
            good_cnt      <= '0;
            index_q       <= '0;
            index_valid_q <= 1'b0;
            illegal_q     <= 1'b0;
            seq_err_q     <= 1'b0;
            locked_q      <= 1'b0;
            wrap_cnt_q    <= '0;
            err_cnt_q     <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            index_valid_q <= 1'b0;
            illegal_q     <= 1'b0;
            seq_err_q     <= 1'b0;
            if (bus.valid_in) begin
                if (!code_legal) begin
                    illegal_q <= 1'b1;
                    state     <= HUNT;
                    locked_q  <= 1'b0;
                    good_cnt  <= '0;
                    if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
                end else if (state == HUNT) begin
                    state         <= CHECK;
                    index_q       <= code_idx;
                    index_valid_q <= 1'b1;
                    good_cnt      <= '0;
                end else if (is_succ) begin
                    index_q       <= code_idx;
                    index_valid_q <= 1'b1;
                    if (state == CHECK) begin
                        good_cnt <= good_cnt + 4'd1;
                        if (good_cnt == 4'(LOCK_CNT - 1)) begin
                            state    <= LOCKED;
                            locked_q <= 1'b1;
                        end
                    end else if (code_idx == '0) begin
                        wrap_cnt_q <= wrap_cnt_q + 8'd1;
                    end
                end else if (ALLOW_HOLD && is_hold) begin
                    index_valid_q <= 1'b1;
                end else begin
                    // Legal but out of sequence: re-anchor on the new index.
                    seq_err_q     <= 1'b1;
                    index_q       <= code_idx;
                    index_valid_q <= 1'b1;
                    state         <= CHECK;
                    locked_q      <= 1'b0;
                    good_cnt      <= '0;
                    if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
                end
            end
        end
    end

    assign bus.index       = index_q;
    assign bus.index_valid = index_valid_q;
    assign bus.illegal     = illegal_q;
    assign bus.seq_err     = seq_err_q;
    assign bus.locked      = locked_q;
    assign bus.wrap_cnt    = wrap_cnt_q;
    assign bus.err_cnt     = err_cnt_q;
endmodule

// File: tb/tb_johnson_decoder.sv
// Bench for johnson_decoder: two instances (hold rejected / hold accepted) compared each
// cycle against a sequence-table model, plus hand-computed expectations at key points.
module tb_johnson_decoder;
    localparam int W    = 4;
    localparam int N    = 2 * W;
    localparam int IW   = $clog2(N);
    localparam int LOCK = 3;

    typedef struct {
        bit anchored;
        int streak;
        int idx;
        bit iv;
        bit ill;
        bit se;
        int wraps;
        int errs;
    } model_t;

    logic clk = 1'b0;
    logic reset_n = 1'b1;
    int   n_tests = 0;
    int   n_fail = 0;

    johnson_decoder_if #(.WIDTH(W)) bus0 ();
    johnson_decoder_if #(.WIDTH(W)) bus1 ();

    johnson_decoder #(.WIDTH(W), .LOCK_CNT(LOCK), .ALLOW_HOLD(1'b0)) dut0 (
        .clk(clk), .reset_n(reset_n), .bus(bus0)
    );
    johnson_decoder #(.WIDTH(W), .LOCK_CNT(LOCK), .ALLOW_HOLD(1'b1)) dut1 (
        .clk(clk), .reset_n(reset_n), .bus(bus1)
    );

    always #5 clk = ~clk;

    // The legal sequence is generated by shifting right with the inverted LSB fed into the MSB.
    function automatic logic [W-1:0] code_of(input int i);
        logic [W-1:0] c;
        c = '0;
        for (int s = 0; s < (i % N); s++) c = {~c[0], c[W-1:1]};
        return c;
    endfunction

    function automatic int johnson_pos(input logic [W-1:0] code);
        logic [W-1:0] c;
        c = '0;
        for (int i = 0; i < N; i++) begin
            if (c == code) return i;
            c = {~c[0], c[W-1:1]};
        end
        return -1;
    endfunction

    function automatic model_t model_reset();
        model_t m;
        m.anchored = 0; m.streak = 0; m.idx = 0;
        m.iv = 0; m.ill = 0; m.se = 0; m.wraps = 0; m.errs = 0;
        return m;
    endfunction

    function automatic model_t model_step(input model_t m_in, input logic v,
                                          input logic [W-1:0] code, input bit hold);
        model_t m;
        int     pos;
        m = m_in;
        m.iv = 0; m.ill = 0; m.se = 0;
        if (!v) return m;
        pos = johnson_pos(code);
        if (pos < 0) begin
            m.ill = 1; m.anchored = 0; m.streak = 0;
            m.errs = (m.errs < 255) ? m.errs + 1 : 255;
        end else if (!m.anchored) begin
            m.anchored = 1; m.streak = 0; m.idx = pos; m.iv = 1;
        end else if (pos == (m.idx + 1) % N) begin
            if (m.streak >= LOCK && pos == 0) m.wraps = (m.wraps + 1) % 256;
            m.streak = (m.streak < LOCK) ? m.streak + 1 : LOCK;
            m.idx = pos; m.iv = 1;
        end else if (hold && pos == m.idx) begin
            m.iv = 1;
        end else begin
            m.se = 1; m.streak = 0; m.idx = pos; m.iv = 1;
            m.errs = (m.errs < 255) ? m.errs + 1 : 255;
        end
        return m;
    endfunction

    model_t m0 = model_reset();
    model_t m1 = model_reset();

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m0 <= model_reset();
            m1 <= model_reset();
        end else begin
            m0 <= model_step(m0, bus0.valid_in, bus0.code_in, 1'b0);
            m1 <= model_step(m1, bus1.valid_in, bus1.code_in, 1'b1);
        end
    end

    task automatic check(input string name, input logic [31:0] actual, input int expected);
        n_tests++;
        if (actual !== 32'(expected)) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic compare(input string tag, input model_t m, input logic [IW-1:0] index,
                           input logic iv, input logic ill, input logic se, input logic lk,
                           input logic [7:0] wc, input logic [7:0] ec);
        check({tag, ".index"},       32'(index), m.idx);
        check({tag, ".index_valid"}, 32'(iv),    int'(m.iv));
        check({tag, ".illegal"},     32'(ill),   int'(m.ill));
        check({tag, ".seq_err"},     32'(se),    int'(m.se));
        check({tag, ".locked"},      32'(lk),    (m.anchored && m.streak >= LOCK) ? 1 : 0);
        check({tag, ".wrap_cnt"},    32'(wc),    m.wraps);
        check({tag, ".err_cnt"},     32'(ec),    m.errs);
    endtask

    always @(negedge clk) begin
        compare("dut0", m0, bus0.index, bus0.index_valid, bus0.illegal, bus0.seq_err,
                bus0.locked, bus0.wrap_cnt, bus0.err_cnt);
        compare("dut1", m1, bus1.index, bus1.index_valid, bus1.illegal, bus1.seq_err,
                bus1.locked, bus1.wrap_cnt, bus1.err_cnt);
    end

    // Present one sample before the next edge; return at the negedge where its result is visible.
    task automatic step(input logic v, input logic [W-1:0] c);
        bus0.valid_in = v; bus0.code_in = c;
        bus1.valid_in = v; bus1.code_in = c;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        bus0.valid_in = 1'b0; bus0.code_in = '0;
        bus1.valid_in = 1'b0; bus1.code_in = '0;
        #1 reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("reset.index",    32'(bus0.index), 0);
        check("reset.locked",   32'(bus0.locked), 0);
        check("reset.err_cnt",  32'(bus0.err_cnt), 0);
        reset_n = 1'b1;

        // Legal run from reset: 0000,1000,1100,1110 locks after the third successor.
        step(1'b1, 4'b0000);
        check("run.index0", 32'(bus0.index), 0);
        check("run.valid0", 32'(bus0.index_valid), 1);
        step(1'b1, 4'b1000);
        step(1'b1, 4'b1100);
        check("run.index2",  32'(bus0.index), 2);
        check("run.unlocked", 32'(bus0.locked), 0);
        step(1'b1, 4'b1110);
        check("run.index3", 32'(bus0.index), 3);
        check("run.locked", 32'(bus0.locked), 1);
        check("run.err",    32'(bus0.err_cnt), 0);

        // Wrap through 7 -> 0 while locked.
        step(1'b1, 4'b1111);
        step(1'b1, 4'b0111);
        check("dec.0111", 32'(bus0.index), 5);
        step(1'b1, 4'b0011);
        step(1'b1, 4'b0001);
        check("dec.0001", 32'(bus0.index), 7);
        check("wrap.before", 32'(bus0.wrap_cnt), 0);
        step(1'b1, 4'b0000);
        check("wrap.index",  32'(bus0.index), 0);
        check("wrap.cnt",    32'(bus0.wrap_cnt), 1);
        check("wrap.locked", 32'(bus0.locked), 1);

        // Illegal code while locked.
        step(1'b1, 4'b1010);
        check("ill.pulse",  32'(bus0.illegal), 1);
        check("ill.locked", 32'(bus0.locked), 0);
        check("ill.err",    32'(bus0.err_cnt), 1);
        check("ill.hold",   32'(bus0.index), 0);
        step(1'b1, 4'b0011);
        check("ill.reanchor", 32'(bus0.index), 6);
        check("ill.no_seq",   32'(bus0.seq_err), 0);

        // Relock, then skip from 1111 to 0011.
        step(1'b1, 4'b0001);
        step(1'b1, 4'b0000);
        step(1'b1, 4'b1000);
        check("relock1", 32'(bus0.locked), 1);
        check("relock1.no_wrap", 32'(bus0.wrap_cnt), 1);
        step(1'b1, 4'b1100);
        step(1'b1, 4'b1110);
        step(1'b1, 4'b1111);
        step(1'b1, 4'b0011);
        check("skip.seq_err", 32'(bus0.seq_err), 1);
        check("skip.index",   32'(bus0.index), 6);
        check("skip.locked",  32'(bus0.locked), 0);
        check("skip.err",     32'(bus0.err_cnt), 2);
        step(1'b1, 4'b0001);
        step(1'b1, 4'b0000);
        step(1'b1, 4'b1000);
        check("relock2", 32'(bus0.locked), 1);

        // Repeated code: rejected by dut0, accepted as a hold by dut1.
        step(1'b1, 4'b1100);
        step(1'b1, 4'b1100);
        check("hold0.seq_err", 32'(bus0.seq_err), 1);
        check("hold0.err",     32'(bus0.err_cnt), 3);
        check("hold1.valid",   32'(bus1.index_valid), 1);
        check("hold1.seq_err", 32'(bus1.seq_err), 0);
        check("hold1.locked",  32'(bus1.locked), 1);
        check("hold1.err",     32'(bus1.err_cnt), 2);

        // valid_in low with a changing code: no pulses, nothing moves.
        step(1'b0, 4'b1010);
        step(1'b0, 4'b0111);
        step(1'b0, 4'b0001);
        check("gate.valid",   32'(bus0.index_valid), 0);
        check("gate.illegal", 32'(bus0.illegal), 0);
        check("gate.index",   32'(bus0.index), 2);

        // Two more locked wraps, bringing wrap_cnt to 3 on both instances.
        for (int i = 3; i <= 16; i++) step(1'b1, code_of(i));
        check("wrap3.dut0",   32'(bus0.wrap_cnt), 3);
        check("wrap3.dut1",   32'(bus1.wrap_cnt), 3);
        check("wrap3.locked", 32'(bus0.locked), 1);

        // Asynchronous reset between edges.
        #2 reset_n = 1'b0;
        #1;
        check("areset.locked", 32'(bus0.locked), 0);
        check("areset.index",  32'(bus0.index), 0);
        check("areset.wrap",   32'(bus0.wrap_cnt), 0);
        check("areset.err",    32'(bus0.err_cnt), 0);
        bus0.valid_in = 1'b0; bus1.valid_in = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        step(1'b0, 4'b0000);
        step(1'b1, 4'b1100);
        check("post.index", 32'(bus0.index), 2);

        // err_cnt saturation under a long burst of illegal codes.
        for (int i = 0; i < 260; i++) step(1'b1, 4'b1010);
        check("sat.err",   32'(bus0.err_cnt), 255);
        check("sat.ill",   32'(bus0.illegal), 1);
        check("sat.index", 32'(bus0.index), 2);
        step(1'b0, 4'b1010);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
